execute_muldiv_unit: RTL and testbench
======================================

# execute_muldiv_unit

Iterative RV32M multiply/divide unit alongside the execute-stage ALU. It accepts one M-extension operation from the execute stage and runs a shift-add or restoring-division sequence over 32 iterations. It stalls the pipeline until the result is ready, then delivers a 32-bit result on a one-cycle done pulse. Flush and reset abort the operation at any point.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled in IDLE and DONE
- op  input  3  MulDivOp, funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- operand_a  input  XLEN  rs1 value, sampled with start
- operand_b  input  XLEN  rs2 value, sampled with start
- flush  input  1  abort the current operation (branch mispredict or trap)
- stall  output  1  combinational; holds the pipeline while the unit is working
- busy  output  1  registered; state != IDLE
- done  output  1  registered; one-cycle pulse when result is valid
- result  output  XLEN  registered; holds the last completed result

## Operation
FSM states and transitions:
- IDLE: start -> PREP.
- PREP: latch op; latch |a| and |b| for signed ops; record sign flags -> CALC.
- CALC: 32 iterations on a 6-bit counter, 0..31 -> FIX after iteration 31.
  - Multiply: 64-bit shift-add accumulator.
  - Divide: restoring division producing a 32-bit quotient and 32-bit remainder.
- FIX: apply sign correction. Select the low half (MUL), high half (MULH*), quotient, or remainder -> DONE.
- DONE: result updated, done = 1.
  - start -> PREP (back-to-back issue).
  - Otherwise -> IDLE.

Arithmetic rules:
- MULHSU: a is signed, b is unsigned.
- Divide by zero: quotient = 0xFFFFFFFF and remainder = a, for both signed and unsigned ops. No sign fixup is applied to the quotient.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Remainder takes the sign of the dividend. Quotient is negated when the operand signs differ.

Boundary rules:
- start while in PREP, CALC or FIX is ignored.
- flush in any state -> IDLE on the next edge. done is not asserted; result is unchanged.
- flush and start in the same cycle: flush wins and the start is dropped.
- reset in any state -> IDLE; counter = 0, result = 0, done = 0, busy = 0.

## Timing
- Reset values: stall = 0 (when start is low), busy = 0, done = 0, result = 0.
- stall = (IDLE & start & !flush) | PREP | CALC | FIX. stall is low in DONE so the pipeline captures result that cycle.
- Latency, with start sampled at cycle N:
  - PREP at N+1.
  - CALC at N+2..N+33.
  - FIX at N+34.
  - DONE (done = 1, result valid) at N+35.
- result stays stable from DONE until the next completion.
- Back-to-back: start in DONE at cycle M gives the next DONE at M+35.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - In PREP, if operand_b == 0, go directly to DONE at N+2.
  - Result for MUL*: 0.
  - Result for DIV/DIVU: 0xFFFFFFFF.
  - Result for REM/REMU: a.
- Not defined: every operation takes the full 35-cycle latency. Results are identical in both builds.

## Structure
- package_project_typedefs: add enum MulDivOp (3-bit, funct3 values) and enum MulDivState (IDLE, PREP, CALC, FIX, DONE). Add constant MULDIV_ITERATIONS = 32.
- One sub-module, muldiv_iter_core, holds the accumulator, shift registers and the per-iteration add/subtract step, controlled by init/step/op signals.
- The top module holds the FSM, iteration counter, sign flags, fixup and output registers.

## Test plan
- MUL 7 x 0xFFFFFFFD (-3), start at N -> stall high N..N+34; done at N+35 with result 0xFFFFFFEB; busy low at N+36.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5. Done at N+2 with MULDIV_EARLY_OUT_EN, N+35 without.
- flush at cycle N+10 of a DIV -> IDLE at N+11, no done pulse, result keeps its previous value. flush and start together in IDLE -> stall stays low, busy stays 0.
- Back-to-back: MUL 3 x 4 (result 12), then DIVU 100 / 7 issued in the DONE cycle -> second done 35 cycles later with result 14. reset asserted mid-CALC -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/package_project_typedefs.sv
// package_project_typedefs: shared types and constants for the RV32M multiply/divide unit.
// Provides muldiv_op_e (funct3 encoding), muldiv_state_e (FSM states), MULDIV_ITERATIONS.
package package_project_typedefs;
   localparam int MULDIV_ITERATIONS = 32;
   typedef enum logic [2:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } muldiv_op_e;
   typedef enum logic [2:0] {
      IDLE, PREP, CALC, FIX, DONE
   } muldiv_state_e;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: 64-bit accumulator performing one shift-add or restoring-divide step per cycle.
// Ports: clk, reset (async, active-high); init loads opa (multiplier/dividend) and opb
// (multiplicand/divisor); step advances one iteration; is_div selects divide; acc = {hi/rem, lo/quot}.
module muldiv_iter_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   opa,
   input  logic [XLEN-1:0]   opb,
   output logic [2*XLEN-1:0] acc
);
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN:0]     add_sum, sub_diff;
   always_comb begin
      add_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      // trial subtract of the shifted partial remainder; a borrow means restore
      sub_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
      acc_d    = acc_q;
      b_d      = b_q;
      if (init) begin
         acc_d = {{XLEN{1'b0}}, opa};
         b_d   = opb;
      end else if (step) begin
         acc_d = !is_div ? {add_sum, acc_q[XLEN-1:1]}
               : sub_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
               : {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= acc_d;
         b_q   <= b_d;
      end
   end
   assign acc = acc_q;
endmodule

// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide unit with pipeline stall and done pulse.
// Ports: clk, reset (async, active-high), start/op/operand_a/operand_b issue an operation,
// flush aborts; stall (comb), busy/done/result (registered).
// Optional MULDIV_EARLY_OUT_EN: operand_b == 0 completes straight from PREP.
module execute_muldiv_unit
   import package_project_typedefs::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   muldiv_state_e     state_q, state_d;
   muldiv_op_e        op_q, op_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
   logic              sa_q, sa_d, sb_q, sb_d, done_q, done_d, busy_q;
   logic              a_sgn, b_sgn;
   logic [XLEN-1:0]   a_abs, b_abs, quo, rem, fix_res;
   logic [2*XLEN-1:0] acc, prod;
   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .reset  (reset),
      .init   (state_q == PREP),
      .step   (state_q == CALC),
      .is_div (op_q[2]),
      .opa    (a_abs),
      .opb    (b_abs),
      .acc    (acc)
   );
   always_comb begin
      // MUL is treated as signed: the low half is identical either way
      a_sgn   = (op_q inside {MUL, MULH, MULHSU, DIV, REM}) & a_q[XLEN-1];
      b_sgn   = (op_q inside {MULH, DIV, REM}) & b_q[XLEN-1];
      a_abs   = a_sgn ? -a_q : a_q;
      b_abs   = b_sgn ? -b_q : b_q;
      prod    = (sa_q ^ sb_q) ? -acc : acc;
      // divide by zero yields all ones from the core; keep it unsigned
      quo     = (b_q == '0) ? '1 : (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem     = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fix_res = op_q[2] ? (op_q[1] ? rem : quo)
              : (op_q == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      result_d = result_q;
      done_d   = 1'b0;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               state_d = start ? PREP : IDLE;
               if (start) begin
                  op_d = muldiv_op_e'(op);
                  a_d  = operand_a;
                  b_d  = operand_b;
               end
            end
            PREP: begin
               sa_d  = a_sgn;
               sb_d  = b_sgn;
               cnt_d = '0;
`ifdef MULDIV_EARLY_OUT_EN
               if (b_q == '0) begin
                  state_d  = DONE;
                  result_d = op_q[2] ? (op_q[1] ? a_q : '1) : '0;
                  done_d   = 1'b1;
               end else begin
                  state_d = CALC;
               end
`else
               state_d = CALC;
`endif
            end
            CALC: begin
               cnt_d   = (cnt_q == 6'(MULDIV_ITERATIONS - 1)) ? '0 : cnt_q + 6'd1;
               state_d = (cnt_q == 6'(MULDIV_ITERATIONS - 1)) ? FIX : CALC;
            end
            FIX: begin
               state_d  = DONE;
               result_d = fix_res;
               done_d   = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= (state_d != IDLE);
      end
   end
   assign stall  = (state_q == IDLE & start & !flush) | (state_q inside {PREP, CALC, FIX});
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: table-driven, hand-sequenced and randomized checks of execute_muldiv_unit.
module tb_execute_muldiv_unit;
   import package_project_typedefs::*;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic        clk = 0, reset = 1, start = 0, flush = 0;
   logic [2:0]  op = 0;
   logic [31:0] a = 0, b = 0;
   logic        stall, busy, done;
   logic [31:0] result;
   int          vecs = 0, errs = 0;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, exp;
   } vec_t;
   vec_t tbl[$];
   always #5 clk = ~clk;
   execute_muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .operand_a(a), .operand_b(b),
      .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
   );
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   function automatic logic [31:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
      longint sx = $signed(x), sy = $signed(y);
      longint ux = {32'b0, x}, uy = {32'b0, y};
      logic [63:0] p;
      case (o)
         MUL:    begin p = ux * uy; return p[31:0]; end
         MULH:   begin p = sx * sy; return p[63:32]; end
         MULHSU: begin p = sx * uy; return p[63:32]; end
         MULHU:  begin p = ux * uy; return p[63:32]; end
         DIV:    begin p = sx / sy; return (y == 0) ? 32'hFFFFFFFF : p[31:0]; end
         DIVU:   return (y == 0) ? 32'hFFFFFFFF : x / y;
         REM:    begin p = sx % sy; return (y == 0) ? x : p[31:0]; end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction
   function automatic int exp_lat(logic [31:0] y);
      return (EARLY && y == 0) ? 2 : 35;
   endfunction
   task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y);
      op = o; a = x; b = y; start = 1;
   endtask
   task automatic wait_done(string nm, output int n);
      bit st_ok = 1;
      n = 0;
      do begin
         @(posedge clk); #1;
         start = 0;
         n++;
         if (done !== 1'b1 && stall !== 1'b1) st_ok = 0;
      end while (done !== 1'b1 && n < 100);
      chk({nm, " stall while working"}, 32'(st_ok), 1);
      chk({nm, " stall in DONE"}, 32'(stall), 0);
   endtask
   task automatic run(string nm, logic [2:0] o, logic [31:0] x, logic [31:0] y);
      int n;
      @(negedge clk);
      issue(o, x, y);
      wait_done(nm, n);
      chk({nm, " latency"}, n, exp_lat(y));
      chk({nm, " result"}, result, model(o, x, y));
      @(posedge clk); #1;
      chk({nm, " done pulse end"}, 32'(done), 0);
      chk({nm, " busy end"}, 32'(busy), 0);
   endtask
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 0;
         1: return 1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction
   initial begin
      int n;
      bit saw;
      tbl.push_back('{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
      tbl.push_back('{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
      tbl.push_back('{MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF});
      tbl.push_back('{MULH,   32'h80000000, 32'h80000000, 32'h40000000});
      tbl.push_back('{DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
      tbl.push_back('{REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
      tbl.push_back('{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000});
      tbl.push_back('{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000});
      tbl.push_back('{DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD});
      tbl.push_back('{REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001});
      tbl.push_back('{DIVU,   32'h00000005, 32'h00000000, 32'hFFFFFFFF});
      tbl.push_back('{REMU,   32'h00000005, 32'h00000000, 32'h00000005});
      tbl.push_back('{DIV,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF});
      tbl.push_back('{REM,    32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9});
      tbl.push_back('{MUL,    32'h12345678, 32'h00000000, 32'h00000000});
      tbl.push_back('{DIVU,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF});
      #12;
      chk("reset stall", 32'(stall), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset done", 32'(done), 0);
      chk("reset result", result, 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      issue(MUL, 7, 32'hFFFFFFFD);
      #1;
      chk("mul stall at issue", 32'(stall), 1);
      wait_done("mul7x-3", n);
      chk("mul7x-3 latency", n, 35);
      chk("mul7x-3 result", result, 32'hFFFFFFEB);
      @(posedge clk); #1;
      chk("mul7x-3 done end", 32'(done), 0);
      chk("mul7x-3 busy end", 32'(busy), 0);
      foreach (tbl[i]) begin
         run($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b);
         chk($sformatf("tbl%0d const", i), result, tbl[i].exp);
      end
      run("pre-flush", MUL, 3, 5);
      @(negedge clk);
      issue(DIV, 100, 3);
      @(posedge clk); #1;
      start = 0;
      repeat (9) @(posedge clk);
      #1 flush = 1;
      @(posedge clk); #1;
      flush = 0;
      chk("flush busy", 32'(busy), 0);
      chk("flush stall", 32'(stall), 0);
      chk("flush done", 32'(done), 0);
      saw = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) saw = 1;
      end
      chk("flush no done", 32'(saw), 0);
      chk("flush result kept", result, 15);
      @(negedge clk);
      issue(MUL, 3, 4);
      flush = 1;
      #1;
      chk("flush+start stall", 32'(stall), 0);
      @(posedge clk); #1;
      start = 0;
      flush = 0;
      chk("flush+start busy", 32'(busy), 0);
      saw = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) saw = 1;
      end
      chk("flush+start idle", 32'(saw), 0);
      @(negedge clk);
      issue(MUL, 3, 4);
      wait_done("b2b first", n);
      chk("b2b first latency", n, 35);
      chk("b2b first result", result, 12);
      issue(DIVU, 100, 7);
      wait_done("b2b second", n);
      chk("b2b second latency", n, 35);
      chk("b2b second result", result, 14);
      @(posedge clk); #1;
      chk("b2b done end", 32'(done), 0);
      @(negedge clk);
      issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      @(posedge clk); #1;
      start = 0;
      repeat (5) @(posedge clk);
      #2 reset = 1;
      #1;
      chk("reset mid busy", 32'(busy), 0);
      chk("reset mid done", 32'(done), 0);
      chk("reset mid result", result, 0);
      chk("reset mid stall", 32'(stall), 0);
      @(negedge clk);
      reset = 0;
      run("post-reset", DIVU, 100, 7);
      for (int i = 0; i < 150; i++)
         run($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick());
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
